// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the frame buffer manager: slot index type,
// slot-count legality check and the metadata field layout inside I_info.
package frame_buffer_pkg;

  // Wide enough for the largest legal slot count (3).
  typedef logic [1:0] slot_t;

  // Metadata layout of I_info / O_info (LSB first).
  localparam int INFO_VS_BIT    = 0;
  localparam int INFO_HS_BIT    = 1;
  localparam int INFO_VLD_BIT   = 2;
  localparam int INFO_H_LSB     = 3;
  localparam int INFO_H_WIDTH   = 10;
  localparam int INFO_W_LSB     = 13;
  localparam int INFO_W_WIDTH   = 11;

  function automatic bit buffer_count_ok(input int n);
    return (n == 2) || (n == 3);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)                   count <= '0;
    else if (clear)                 count <= '0;
    else if (inc && (count != '1))  count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/frame_buffer_manager.sv
// Hands frame slots between one writer and one reader (double or triple
// buffering), latching per-frame metadata and swapping only on frame events.
module frame_buffer_manager
  import frame_buffer_pkg::*;
#(
  parameter int BUFFER_COUNT = 3,
  parameter int INFO_WIDTH   = 24,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic                            I_write_done,
  input  logic [INFO_WIDTH-1:0]           I_info,
  input  logic                            I_read_start,
  input  logic                            I_counter_clear,
  output logic [$clog2(BUFFER_COUNT)-1:0] O_write_sel,
  output logic [$clog2(BUFFER_COUNT)-1:0] O_read_sel,
  output logic                            O_write_ready,
  output logic [INFO_WIDTH-1:0]           O_info,
  output logic                            O_data_valid,
  output logic                            O_buffer_updated,
  output logic [CNT_WIDTH-1:0]            O_drop_count,
  output logic [CNT_WIDTH-1:0]            O_repeat_count,
  output logic                            O_overrun
);

  localparam int SEL_W = $clog2(BUFFER_COUNT);

  if (!buffer_count_ok(BUFFER_COUNT)) begin : g_bad_count
    $error("frame_buffer_manager: BUFFER_COUNT must be 2 or 3");
  end

  slot_t w, r, l, w_n, r_n, l_n;
  logic  l_valid, lv_n, pending, pend_n;
  logic  accept, swapped, drop_inc, rep_inc, ovr_n;
  logic [INFO_WIDTH-1:0] info   [BUFFER_COUNT];
  logic [INFO_WIDTH-1:0] info_n [BUFFER_COUNT];
  logic [INFO_WIDTH-1:0] info_rd;

  always_comb begin
    w_n      = w;
    r_n      = r;
    l_n      = l;
    lv_n     = l_valid;
    pend_n   = pending;
    accept   = 1'b0;
    swapped  = 1'b0;
    drop_inc = 1'b0;
    rep_inc  = 1'b0;
    ovr_n    = O_overrun;
    if (BUFFER_COUNT == 3) begin
      accept = I_write_done;
      if (I_write_done && I_read_start) begin
        // Reader takes the frame just finished; any parked frame is lost.
        r_n      = w;
        w_n      = r;
        swapped  = 1'b1;
        drop_inc = l_valid;
        lv_n     = 1'b0;
      end else if (I_write_done) begin
        drop_inc = l_valid;
        w_n      = l;
        l_n      = w;
        lv_n     = 1'b1;
      end else if (I_read_start) begin
        if (l_valid) begin
          r_n     = l;
          l_n     = r;
          lv_n    = 1'b0;
          swapped = 1'b1;
        end else begin
          rep_inc = O_data_valid;
        end
      end
    end else begin
      // Writer is stalled while a finished frame waits for the reader.
      accept = I_write_done && !pending;
      ovr_n  = O_overrun | (I_write_done && pending);
      if (I_read_start && (pending || accept)) begin
        w_n     = r;
        r_n     = w;
        pend_n  = 1'b0;
        swapped = 1'b1;
      end else if (accept) begin
        pend_n  = 1'b1;
      end else if (I_read_start) begin
        rep_inc = O_data_valid;
      end
    end
  end

  always_comb begin
    info_rd = '0;
    for (int i = 0; i < BUFFER_COUNT; i++) begin
      info_n[i] = (accept && (w == slot_t'(i))) ? I_info : info[i];
    end
    // Look up with next-state values so O_info lines up with O_read_sel.
    for (int i = 0; i < BUFFER_COUNT; i++) begin
      if (r_n == slot_t'(i)) info_rd = info_n[i];
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      w                <= 2'd0;
      r                <= 2'd1;
      l                <= 2'd2;
      l_valid          <= 1'b0;
      pending          <= 1'b0;
      O_write_ready    <= 1'b1;
      O_info           <= '0;
      O_data_valid     <= 1'b0;
      O_buffer_updated <= 1'b0;
      O_overrun        <= 1'b0;
      for (int i = 0; i < BUFFER_COUNT; i++) info[i] <= '0;
    end else begin
      w                <= w_n;
      r                <= r_n;
      l                <= l_n;
      l_valid          <= lv_n;
      pending          <= pend_n;
      O_write_ready    <= !pend_n;
      O_info           <= info_rd;
      O_data_valid     <= O_data_valid | swapped;
      O_buffer_updated <= swapped;
      O_overrun        <= ovr_n;
      info             <= info_n;
    end
  end

  assign O_write_sel = w[SEL_W-1:0];
  assign O_read_sel  = r[SEL_W-1:0];

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .inc     (drop_inc),
    .clear   (I_counter_clear),
    .count   (O_drop_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_repeat_cnt (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .inc     (rep_inc),
    .clear   (I_counter_clear),
    .count   (O_repeat_count)
  );

endmodule
